player_life_fsm: RTL

- Per-player life-cycle controller that drives the `explosion` and `game_over` inputs of the lives counter and consumes its `lives_left` output.
- Turns raw collision hits into one explosion event per death.
- Sequences the explosion, respawn-wait and invulnerability periods in video frames.
- Gates player visibility and control. Sits between the collision detector and the player draw/move logic.

---
 rtl/player_life_fsm.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/player_life_fsm.sv
// player_life_fsm: per-player life-cycle controller.
// Turns collision hits into one explosion per death and sequences the
// EXPLODING -> RESPAWN -> INVULN periods, counted in video frames. On the
// last explosion frame with no lives left it parks in GAME_OVER until reset.
//
// Optional build macro: PLAYER_LIFE_BLINK_EN
//   defined   - player_visible blinks during INVULN (half-period BLINK_FRAMES)
//   undefined - player_visible stays 1 during INVULN, no blink logic built
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   startOfFrame   one-cycle pulse at the start of each video frame
//   hit            player/hazard collision (level or pulse)
//   lives_left     remaining lives from the lives counter
//   explosion      high for the whole EXPLODING state (to lives counter)
//   game_over      high in GAME_OVER, sticky until reset
//   player_visible player sprite draw enable
//   player_enable  player movement/fire enable
//   invulnerable   high in INVULN
module player_life_fsm #(
  parameter int unsigned EXPLODE_FRAMES = 30,
  parameter int unsigned RESPAWN_FRAMES = 60,
  parameter int unsigned INVULN_FRAMES  = 120,
  parameter int unsigned BLINK_FRAMES   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       startOfFrame,
  input  logic       hit,
  input  logic [2:0] lives_left,
  output logic       explosion,
  output logic       game_over,
  output logic       player_visible,
  output logic       player_enable,
  output logic       invulnerable
);

  localparam int unsigned CNT_W = 8;

  // Reject parameter values the 8-bit frame counter cannot honour.
  if (EXPLODE_FRAMES < 1 || EXPLODE_FRAMES > 255 ||
      RESPAWN_FRAMES < 1 || RESPAWN_FRAMES > 255 ||
      INVULN_FRAMES  < 1 || INVULN_FRAMES  > 255 ||
      BLINK_FRAMES   < 2 || BLINK_FRAMES   > 64  ||
      (BLINK_FRAMES & (BLINK_FRAMES - 1)) != 0) begin : g_param_check
    $error("player_life_fsm: frame parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_ALIVE     = 3'd0,
    ST_EXPLODING = 3'd1,
    ST_RESPAWN   = 3'd2,
    ST_INVULN    = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               vis_inv_d;
  logic               explosion_d, game_over_d, visible_d, enable_d, invuln_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next state and frame counter; every exit clears the counter for the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ALIVE: begin
        cnt_d = '0;
        if (hit) state_d = ST_EXPLODING;
      end
      ST_EXPLODING: begin
        if (startOfFrame) begin
          if (cnt_inc == CNT_W'(EXPLODE_FRAMES)) begin
            cnt_d   = '0;
            // Lives counter has already decremented by the time we get here.
            state_d = (lives_left == 3'd0) ? ST_GAME_OVER : ST_RESPAWN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_RESPAWN: begin
        if (startOfFrame) begin
          if (cnt_inc == CNT_W'(RESPAWN_FRAMES)) begin
            cnt_d   = '0;
            state_d = ST_INVULN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_INVULN: begin
        if (startOfFrame) begin
          if (cnt_inc == CNT_W'(INVULN_FRAMES)) begin
            cnt_d   = '0;
            state_d = ST_ALIVE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_GAME_OVER: cnt_d = '0;
      default: begin
        state_d = ST_ALIVE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef PLAYER_LIFE_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES);

  logic blink_q, blink_d;

  // Phase starts at 0 on INVULN entry and flips every BLINK_FRAMES frames.
  always_comb begin
    blink_d = 1'b0;
    if (state_q == ST_INVULN && state_d == ST_INVULN) begin
      blink_d = blink_q;
      if (startOfFrame && cnt_inc[BLINK_W-1:0] == '0) blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_q <= 1'b0;
    else        blink_q <= blink_d;
  end

  assign vis_inv_d = ~blink_d;
`else
  assign vis_inv_d = 1'b1;
`endif

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    explosion_d = 1'b0;
    game_over_d = 1'b0;
    visible_d   = 1'b0;
    enable_d    = 1'b0;
    invuln_d    = 1'b0;
    case (state_d)
      ST_ALIVE: begin
        visible_d = 1'b1;
        enable_d  = 1'b1;
      end
      ST_EXPLODING: begin
        explosion_d = 1'b1;
        visible_d   = 1'b1;
      end
      ST_INVULN: begin
        invuln_d  = 1'b1;
        enable_d  = 1'b1;
        visible_d = vis_inv_d;
      end
      ST_GAME_OVER: game_over_d = 1'b1;
      default: ;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_ALIVE;
      cnt_q          <= '0;
      explosion      <= 1'b0;
      game_over      <= 1'b0;
      player_visible <= 1'b1;
      player_enable  <= 1'b1;
      invulnerable   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      explosion      <= explosion_d;
      game_over      <= game_over_d;
      player_visible <= visible_d;
      player_enable  <= enable_d;
      invulnerable   <= invuln_d;
    end
  end

endmodule
